// File: rtl/axi_slave_mem.sv
// AXI3 slave backed by an internal byte-addressable memory.
// Independent write and read engines, one outstanding transaction each.
// Bursts: FIXED/INCR/WRAP up to 16 beats, byte strobes, SLVERR on
// out-of-range or illegal bursts.
// Ports:
//   aclk, arst              clock, synchronous active-high reset
//   aw* / awready           write address channel
//   w*  / wready            write data channel
//   b*  / bready            write response channel
//   ar* / arready           read address channel
//   r*  / rready            read data channel
module axi_slave_mem #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned MEM_BYTES  = 4096
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic [3:0]            awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [3:0]            wid,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [3:0]            bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [3:0]            arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [3:0]            rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int unsigned OFF_W     = $clog2(STRB_WIDTH);
    localparam int unsigned MEM_AW    = $clog2(MEM_BYTES);
    localparam int unsigned IDX_W     = MEM_AW - OFF_W;
    localparam int unsigned MEM_WORDS = MEM_BYTES / STRB_WIDTH;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Address of the beat following addr for the given burst type.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size,
        input logic [1:0] burst, input logic [3:0] len);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] bnd;
        step = ADDR_WIDTH'(1) << size;
        bnd  = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~(bnd - ADDR_WIDTH'(1))) |
                                 ((addr + step) & (bnd - ADDR_WIDTH'(1)));
            default: next_addr = (addr & ~(step - ADDR_WIDTH'(1))) + step;
        endcase
    endfunction

    // Burst shapes this slave cannot honour: oversize beat, reserved type, bad wrap length.
    function automatic logic illegal_cfg(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [3:0] len);
        illegal_cfg = (size > 3'(OFF_W)) || (burst == 2'b11) ||
                      ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        in_range = addr < ADDR_WIDTH'(MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        word_idx = addr[MEM_AW-1:OFF_W];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_e              w_state_q, w_state_d;
    logic [3:0]            aw_id_q, aw_id_d, aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic                  w_err_q, w_err_d, beat_err;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [3:0]            bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  w_hs;

    r_state_e              r_state_q, r_state_d;
    logic [3:0]            ar_id_q, ar_id_d, ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, rd_addr;
    logic [2:0]            ar_size_q, ar_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [3:0]            rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rd_load, rd_ill;

    assign w_hs = wvalid && wready_q;

    // Write engine next-state and response.
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        beat_err   = !in_range(aw_addr_q) || (wlast != (w_cnt_q == aw_len_q)) ||
                     (wid != aw_id_q);
        case (w_state_q)
            W_IDLE: if (awvalid && awready_q) begin
                aw_id_d    = awid;
                aw_addr_d  = awaddr;
                aw_len_d   = awlen;
                aw_size_d  = awsize;
                aw_burst_d = awburst;
                w_cnt_d    = 4'd0;
                // Burst-shape errors are known up front, so seed the flag here.
                w_err_d    = illegal_cfg(awsize, awburst, awlen);
                w_state_d  = W_DATA;
            end
            W_DATA: if (w_hs) begin
                w_err_d   = w_err_q || beat_err;
                aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_burst_q, aw_len_q);
                w_cnt_d   = w_cnt_q + 4'd1;
                if (w_cnt_q == aw_len_q) begin
                    bid_d     = aw_id_q;
                    bresp_d   = (w_err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (bvalid_q && bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read engine next-state; each beat's data is fetched into the output register.
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        rid_d      = rid_q;
        rlast_d    = rlast_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_load    = 1'b0;
        rd_addr    = ar_addr_q;
        rd_ill     = illegal_cfg(ar_size_q, ar_burst_q, ar_len_q);
        case (r_state_q)
            R_IDLE: if (arvalid && arready_q) begin
                ar_id_d    = arid;
                ar_addr_d  = araddr;
                ar_len_d   = arlen;
                ar_size_d  = arsize;
                ar_burst_d = arburst;
                r_cnt_d    = 4'd0;
                rid_d      = arid;
                rlast_d    = (arlen == 4'd0);
                rd_load    = 1'b1;
                rd_addr    = araddr;
                rd_ill     = illegal_cfg(arsize, arburst, arlen);
                r_state_d  = R_DATA;
            end
            R_DATA: if (rvalid_q && rready) begin
                if (rlast_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    rd_addr   = next_addr(ar_addr_q, ar_size_q, ar_burst_q, ar_len_q);
                    ar_addr_d = rd_addr;
                    r_cnt_d   = r_cnt_q + 4'd1;
                    rlast_d   = ((r_cnt_q + 4'd1) == ar_len_q);
                    rd_load   = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Memory is read before this edge's write lands, giving read-before-write.
        if (rd_load) begin
            rdata_d = in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
            rresp_d = (rd_ill || !in_range(rd_addr)) ? RESP_SLVERR : RESP_OKAY;
        end
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // Control and output registers.
    always_ff @(posedge aclk) begin
        if (arst) begin
            w_state_q <= W_IDLE;   r_state_q <= R_IDLE;
            aw_id_q   <= '0;       aw_addr_q <= '0;   aw_len_q  <= '0;
            aw_size_q <= '0;       aw_burst_q <= '0;  w_cnt_q   <= '0;
            w_err_q   <= 1'b0;     awready_q <= 1'b0; wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;     bid_q     <= '0;   bresp_q   <= '0;
            ar_id_q   <= '0;       ar_addr_q <= '0;   ar_len_q  <= '0;
            ar_size_q <= '0;       ar_burst_q <= '0;  r_cnt_q   <= '0;
            arready_q <= 1'b0;     rvalid_q  <= 1'b0; rlast_q   <= 1'b0;
            rid_q     <= '0;       rdata_q   <= '0;   rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d; r_state_q <= r_state_d;
            aw_id_q   <= aw_id_d;   aw_addr_q <= aw_addr_d; aw_len_q  <= aw_len_d;
            aw_size_q <= aw_size_d; aw_burst_q <= aw_burst_d; w_cnt_q <= w_cnt_d;
            w_err_q   <= w_err_d;   awready_q <= awready_d; wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;  bid_q     <= bid_d;     bresp_q   <= bresp_d;
            ar_id_q   <= ar_id_d;   ar_addr_q <= ar_addr_d; ar_len_q  <= ar_len_d;
            ar_size_q <= ar_size_d; ar_burst_q <= ar_burst_d; r_cnt_q <= r_cnt_d;
            arready_q <= arready_d; rvalid_q  <= rvalid_d;  rlast_q   <= rlast_d;
            rid_q     <= rid_d;     rdata_q   <= rdata_d;   rresp_q   <= rresp_d;
        end
    end

    // Byte-lane writes; out-of-range beats are dropped, reset blocks the edge's write.
    always_ff @(posedge aclk) begin
        if (w_hs && !arst && in_range(aw_addr_q)) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) mem[word_idx(aw_addr_q)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: table of bursts, a byte-level
// reference memory, and queues of expected B and R responses.
module tb_axi_slave_mem;

    localparam int unsigned MEM = 4096;
    localparam int unsigned NV  = 21;

    logic        aclk, arst;
    logic [3:0]  awid, awlen, wid, bid, arid, arlen, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_slave_mem dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] d0;
        logic [3:0]  strb;
        int          last_at;
        logic [1:0]  exp_resp;   // bresp for writes, beat-0 rresp for reads
        bit          chk0;
        logic [31:0] exp0;       // beat-0 rdata for reads
    } vec_t;

    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;

    vec_t        vecs [NV];
    bexp_t       bq[$];
    rexp_t       rq[$];
    logic [7:0]  ref_mem [MEM];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst, input logic [3:0] len,
                                              input int k);
        logic [31:0] step, bnd, base;
        step = 32'd1 << size;
        if (k == 0 || burst == 2'b00) return a;
        if (burst == 2'b10) begin
            bnd  = (32'(len) + 32'd1) * step;
            base = a - (a % bnd);
            return base + ((a - base + 32'(k) * step) % bnd);
        end
        return (a - (a % step)) + 32'(k) * step;
    endfunction

    function automatic bit ref_illegal(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [3:0] len);
        return (size > 3'd2) || (burst == 2'b11) ||
               ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        logic [11:0] b;
        if (a >= 32'(MEM)) return 32'h0;
        b = {a[11:2], 2'b00};
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[b + 12'(i)];
        return w;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb);
        logic [31:0] ba, d;
        for (int k = 0; k <= int'(len); k++) begin
            ba = beat_addr(a, size, burst, len, k);
            d  = d0 + 32'(k);
            if (ba < 32'(MEM))
                for (int i = 0; i < 4; i++)
                    if (strb[i]) ref_mem[{ba[11:2], 2'b00} + 12'(i)] = d[8*i +: 8];
        end
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                            input logic [3:0] strb, input int last_at, input logic [1:0] exp_resp,
                            input int bdelay);
        int n;
        bexp_t e;
        bq.push_back('{id, exp_resp});
        ref_write(a, len, size, burst, d0, strb);
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        chk("aw_accept", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        chk("aw_drop", 32'(awready), 32'd0);
        for (int k = 0; k <= int'(len); k++) begin
            wid = id; wdata = d0 + 32'(k); wstrb = strb; wlast = (k == last_at); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            if (!wready) chk("w_accept", 32'(wready), 32'd1);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_latency", 32'(bvalid), 32'd1);
        for (int c = 0; c < bdelay; c++) begin
            chk("b_hold_valid", 32'(bvalid), 32'd1);
            chk("b_hold_id", 32'(bid), 32'(bq[0].id));
            chk("b_hold_resp", 32'(bresp), 32'(bq[0].resp));
            @(negedge aclk);
        end
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        e = bq.pop_front();
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bid", 32'(bid), 32'(e.id));
        chk("bresp", 32'(bresp), 32'(e.resp));
        @(negedge aclk);
        bready = 1'b0;
        chk("aw_ready_after_b", 32'(awready), 32'd1);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                            input bit chk0, input logic [31:0] exp0, input logic [1:0] exp_r0);
        int n, beat;
        logic [31:0] ba;
        bit ill;
        ill = ref_illegal(size, burst, len);
        for (int k = 0; k <= int'(len); k++) begin
            ba = beat_addr(a, size, burst, len, k);
            rq.push_back('{id, ref_word(ba), (ill || ba >= 32'(MEM)) ? 2'b10 : 2'b00,
                           k == int'(len)});
        end
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        chk("ar_accept", 32'(arready), 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        chk("ar_drop", 32'(arready), 32'd0);
        beat = 0; n = 0;
        while (beat <= int'(len) && n < 100) begin
            rready = toggle ? n[0] : 1'b1;
            chk("rvalid", 32'(rvalid), 32'd1);
            if (rvalid && rq.size() > 0) begin
                chk("rdata", rdata, rq[0].data);
                chk("rresp", 32'(rresp), 32'(rq[0].resp));
                chk("rlast", 32'(rlast), 32'(rq[0].last));
                chk("rid", 32'(rid), 32'(rq[0].id));
                if (rready) begin
                    if (chk0 && beat == 0) begin
                        chk("rdata_beat0", rdata, exp0);
                        chk("rresp_beat0", 32'(rresp), 32'(exp_r0));
                    end
                    void'(rq.pop_front());
                    beat++;
                end
            end
            @(negedge aclk);
            n++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) chk("r_beats", 32'(beat), 32'(len) + 32'd1);
        rq.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, 32'(awready), 32'd0);
        chk({tag, "_wready"},  32'(wready),  32'd0);
        chk({tag, "_bvalid"},  32'(bvalid),  32'd0);
        chk({tag, "_bid"},     32'(bid),     32'd0);
        chk({tag, "_bresp"},   32'(bresp),   32'd0);
        chk({tag, "_arready"}, 32'(arready), 32'd0);
        chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
        chk({tag, "_rid"},     32'(rid),     32'd0);
        chk({tag, "_rdata"},   rdata,        32'd0);
        chk({tag, "_rresp"},   32'(rresp),   32'd0);
        chk({tag, "_rlast"},   32'(rlast),   32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        //            wr  addr      len   size  burst d0            strb  last rsp   chk0 exp0
        vecs[0]  = '{1, 32'h000, 4'd0, 3'd2, 2'd1, 32'h11111111, 4'hF, 0, 2'd0, 0, 32'h0};
        vecs[1]  = '{1, 32'h100, 4'd3, 3'd2, 2'd1, 32'h000000A0, 4'hF, 3, 2'd0, 0, 32'h0};
        vecs[2]  = '{0, 32'h100, 4'd3, 3'd2, 2'd1, 32'h0,        4'h0, 0, 2'd0, 1, 32'hA0};
        vecs[3]  = '{1, 32'h040, 4'd0, 3'd2, 2'd1, 32'hFFFFFFFF, 4'hF, 0, 2'd0, 0, 32'h0};
        vecs[4]  = '{1, 32'h040, 4'd0, 3'd2, 2'd1, 32'h12345678, 4'h5, 0, 2'd0, 0, 32'h0};
        vecs[5]  = '{0, 32'h040, 4'd0, 3'd2, 2'd1, 32'h0,        4'h0, 0, 2'd0, 1, 32'hFF34FF78};
        vecs[6]  = '{1, 32'h018, 4'd3, 3'd2, 2'd2, 32'h000000B0, 4'hF, 3, 2'd0, 0, 32'h0};
        vecs[7]  = '{0, 32'h010, 4'd3, 3'd2, 2'd1, 32'h0,        4'h0, 0, 2'd0, 1, 32'hB2};
        vecs[8]  = '{1, 32'h1000, 4'd0, 3'd2, 2'd1, 32'hDEADBEEF, 4'hF, 0, 2'd2, 0, 32'h0};
        vecs[9]  = '{0, 32'h000, 4'd0, 3'd2, 2'd1, 32'h0,        4'h0, 0, 2'd0, 1, 32'h11111111};
        vecs[10] = '{1, 32'hFFC, 4'd0, 3'd2, 2'd1, 32'h55AA55AA, 4'hF, 0, 2'd0, 0, 32'h0};
        vecs[11] = '{0, 32'hFFC, 4'd1, 3'd2, 2'd1, 32'h0,        4'h0, 0, 2'd0, 1, 32'h55AA55AA};
        vecs[12] = '{1, 32'h500, 4'd3, 3'd2, 2'd1, 32'h000000C0, 4'hF, 1, 2'd2, 0, 32'h0};
        vecs[13] = '{0, 32'h500, 4'd3, 3'd2, 2'd1, 32'h0,        4'h0, 0, 2'd0, 1, 32'hC0};
        vecs[14] = '{1, 32'h300, 4'd2, 3'd2, 2'd0, 32'h000000D0, 4'hF, 2, 2'd0, 0, 32'h0};
        vecs[15] = '{0, 32'h300, 4'd1, 3'd2, 2'd0, 32'h0,        4'h0, 0, 2'd0, 1, 32'hD2};
        vecs[16] = '{1, 32'h200, 4'd0, 3'd2, 2'd3, 32'h000000E0, 4'hF, 0, 2'd2, 0, 32'h0};
        vecs[17] = '{0, 32'h200, 4'd0, 3'd2, 2'd3, 32'h0,        4'h0, 0, 2'd2, 1, 32'hE0};
        vecs[18] = '{0, 32'h100, 4'd0, 3'd3, 2'd1, 32'h0,        4'h0, 0, 2'd2, 1, 32'hA0};
        vecs[19] = '{1, 32'h600, 4'd0, 3'd3, 2'd1, 32'h000000F1, 4'hF, 0, 2'd2, 0, 32'h0};
        vecs[20] = '{0, 32'h600, 4'd0, 3'd2, 2'd1, 32'h0,        4'h0, 0, 2'd0, 1, 32'hF1};

        repeat (3) @(negedge aclk);
        chk_all_zero("reset");
        arst = 1'b0;
        @(negedge aclk);
        chk("rst_release_awready", 32'(awready), 32'd1);
        chk("rst_release_arready", 32'(arready), 32'd1);

        for (int i = 0; i < int'(NV); i++) begin
            if (vecs[i].wr)
                wr_burst(4'(i), vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                         vecs[i].d0, vecs[i].strb, vecs[i].last_at, vecs[i].exp_resp, 0);
            else
                rd_burst(4'(i), vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, 1'b0,
                         vecs[i].chk0, vecs[i].exp0, vecs[i].exp_resp);
        end

        // bready held low for 5 cycles
        wr_burst(4'd9, 32'h700, 4'd0, 3'd2, 2'd1, 32'h77777777, 4'hF, 0, 2'd0, 5);
        // rready toggling across a 4-beat read
        rd_burst(4'd5, 32'h100, 4'd3, 3'd2, 2'd1, 1'b1, 1'b1, 32'hA0, 2'd0);

        // reset in the middle of a write burst
        wr_burst(4'd1, 32'h804, 4'd0, 3'd2, 2'd1, 32'h12121212, 4'hF, 0, 2'd0, 0);
        ref_write(32'h800, 4'd0, 3'd2, 2'd1, 32'h99, 4'hF);
        awid = 4'd2; awaddr = 32'h800; awlen = 4'd3; awsize = 3'd2; awburst = 2'd1;
        awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        wid = 4'd2; wdata = 32'h99; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        @(negedge aclk);
        wdata = 32'h9A; arst = 1'b1;
        @(negedge aclk);
        chk_all_zero("midburst_rst");
        wvalid = 1'b0; arst = 1'b0;
        @(negedge aclk);
        chk("post_rst_awready", 32'(awready), 32'd1);
        chk("post_rst_arready", 32'(arready), 32'd1);
        chk("post_rst_bvalid", 32'(bvalid), 32'd0);
        rd_burst(4'd3, 32'h800, 4'd1, 3'd2, 2'd1, 1'b0, 1'b1, 32'h99, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
